// File: rtl/complex_pkg.sv
// Shared encodings and width helpers for the sequential complex divider.
package complex_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Dividend width: the 2W-bit numerator magnitude shifted left by FRAC.
  function automatic int nd_w(input int w, input int frac);
    return 2 * w + frac;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int den_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/complex_divider_udiv_seq.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module udiv_seq #(
  parameter int ND = 20,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [ND-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic [ND-1:0] quot_d_o
);

  // The quotient register doubles as the dividend shift register.
  logic [ND-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW:0]   trial;

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    trial  = {rem_q, quot_q[ND-1]};
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
    end else if (step_i) begin
      if (trial >= {1'b0, divisor_i}) begin
        rem_d  = DW'(trial - {1'b0, divisor_i});
        quot_d = {quot_q[ND-2:0], 1'b1};
      end else begin
        rem_d  = trial[DW-1:0];
        quot_d = {quot_q[ND-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    quot_q <= quot_d;
    rem_q  <= rem_d;
  end

  assign quot_d_o = quot_d;

endmodule

// File: rtl/complex_divider.sv
// Sequential fixed-point complex divider: one multiply cycle, then ND restoring steps.
module complex_divider
  import complex_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [W-1:0]   areal,
  input  logic signed [W-1:0]   aimaginary,
  input  logic signed [W-1:0]   breal,
  input  logic signed [W-1:0]   bimaginary,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic signed [2*W-1:0] resultreal,
  output logic signed [2*W-1:0] resultimaginary
);

  localparam int ND = nd_w(W, FRAC);
  localparam int PW = prod_w(W);
  localparam int DW = den_w(W);
  localparam int CW = $clog2(ND);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dbz_q, dbz_d;
  logic signed [DW-1:0] rr_q, rr_d, ri_q, ri_d;

  logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
  logic                sr_q, si_q;
  logic [DW-1:0]       den_q;

  logic signed [DW-1:0] p_rr, p_ii, p_ir, p_ri, bsq_r, bsq_i;
  logic signed [PW-1:0] nr, ni;
  logic                 nr_neg, ni_neg;
  logic [DW-1:0]        nr_mag, ni_mag, den;
  logic                 div_load, div_step;
  logic [ND-1:0]        qr_next, qi_next;
  logic signed [DW-1:0] qr_s, qi_s;

  // Multiply stage: conjugate products and |b|^2 from the captured operands
  assign p_rr   = ar_q * br_q;
  assign p_ii   = ai_q * bi_q;
  assign p_ir   = ai_q * br_q;
  assign p_ri   = ar_q * bi_q;
  assign bsq_r  = br_q * br_q;
  assign bsq_i  = bi_q * bi_q;
  assign nr     = PW'(p_rr) + PW'(p_ii);
  assign ni     = PW'(p_ir) - PW'(p_ri);
  assign den    = $unsigned(bsq_r) + $unsigned(bsq_i);
  assign nr_neg = nr[PW-1];
  assign ni_neg = ni[PW-1];
  assign nr_mag = DW'(nr_neg ? -nr : nr);
  assign ni_mag = DW'(ni_neg ? -ni : ni);

  assign div_load = (state_q == S_MUL) && (den != '0);
  assign div_step = (state_q == S_DIV);

  udiv_seq #(.ND(ND), .DW(DW)) u_div_re (
    .clk        (clk),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (ND'(nr_mag) << FRAC),
    .divisor_i  (den_q),
    .quot_d_o   (qr_next)
  );

  udiv_seq #(.ND(ND), .DW(DW)) u_div_im (
    .clk        (clk),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (ND'(ni_mag) << FRAC),
    .divisor_i  (den_q),
    .quot_d_o   (qi_next)
  );

  // Quotient magnitude always fits in 2W bits, so plain truncation is safe.
  assign qr_s = $signed(DW'(qr_next));
  assign qi_s = $signed(DW'(qi_next));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    rr_d    = rr_q;
    ri_d    = ri_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_MUL;
      end
      S_MUL: begin
        if (den == '0) begin
          state_d = S_DONE;
          dbz_d   = 1'b1;
          rr_d    = '0;
          ri_d    = '0;
        end else begin
          state_d = S_DIV;
          cnt_d   = CW'(ND - 1);
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          dbz_d   = 1'b0;
          rr_d    = sr_q ? -qr_s : qr_s;
          ri_d    = si_q ? -qi_s : qi_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      rr_q    <= '0;
      ri_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      rr_q    <= rr_d;
      ri_q    <= ri_d;
    end
  end

  // Operand capture and per-operation signs need no reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start) begin
      ar_q <= areal;
      ai_q <= aimaginary;
      br_q <= breal;
      bi_q <= bimaginary;
    end
    if (state_q == S_MUL) begin
      sr_q  <= nr_neg;
      si_q  <= ni_neg;
      den_q <= den;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign div_by_zero     = dbz_q;
  assign resultreal      = rr_q;
  assign resultimaginary = ri_q;

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider: vector table plus multi-cycle corner sequences.
module tb_complex_divider;

  localparam int W    = 8;
  localparam int FRAC = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic signed [W-1:0]   areal = '0, aimaginary = '0, breal = '0, bimaginary = '0;
  logic                  busy, done, div_by_zero;
  logic signed [2*W-1:0] resultreal, resultimaginary;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int ar, ai, br, bi;
    int rr, ri, dbz, lat;
  } vec_t;

  vec_t vecs[11];

  complex_divider #(.W(W), .FRAC(FRAC)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .areal           (areal),
    .aimaginary      (aimaginary),
    .breal           (breal),
    .bimaginary      (bimaginary),
    .busy            (busy),
    .done            (done),
    .div_by_zero     (div_by_zero),
    .resultreal      (resultreal),
    .resultimaginary (resultimaginary)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int ar, input int ai, input int br, input int bi);
    areal      = W'(ar);
    aimaginary = W'(ai);
    breal      = W'(br);
    bimaginary = W'(bi);
  endtask

  // Count edges from the start-sampling edge (1) until done is seen.
  task automatic run_op(input int ar, input int ai, input int br, input int bi,
                        output int lat);
    @(negedge clk);
    set_ops(ar, ai, br, bi);
    start = 1'b1;
    lat   = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("run_op_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int t[3];
    int k;
    int pulses;

    vecs[0]  = '{10, 20, 30, 40, 7, 1, 0, 22};
    vecs[1]  = '{-128, -128, 1, 0, -2048, -2048, 0, 22};
    vecs[2]  = '{-128, 0, 0, -1, 0, -2048, 0, 22};
    vecs[3]  = '{5, 5, 0, 0, 0, 0, 1, 2};
    vecs[4]  = '{1, 0, 3, 0, 5, 0, 0, 22};
    vecs[5]  = '{-1, 0, 3, 0, -5, 0, 0, 22};
    vecs[6]  = '{3, 4, 1, 0, 48, 64, 0, 22};
    vecs[7]  = '{1, 1, 1, 1, 16, 0, 0, 22};
    vecs[8]  = '{1, 0, 0, 1, 0, -16, 0, 22};
    vecs[9]  = '{127, 127, -128, -128, -15, 0, 0, 22};
    vecs[10] = '{7, -3, 2, 0, 56, -24, 0, 22};

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_rr", int'(resultreal), 0);
    chk("rst_ri", int'(resultimaginary), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rr", i), int'(resultreal), vecs[i].rr);
      chk($sformatf("v%0d_ri", i), int'(resultimaginary), vecs[i].ri);
      chk($sformatf("v%0d_dbz", i), int'(div_by_zero), vecs[i].dbz);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_fall", i), int'(done), 0);
      chk($sformatf("v%0d_busy_fall", i), int'(busy), 0);
      chk($sformatf("v%0d_rr_hold", i), int'(resultreal), vecs[i].rr);
    end

    // New operands and a start pulse during DIV must not disturb the operation.
    @(negedge clk);
    set_ops(10, 20, 30, 40);
    start = 1'b1;
    lat   = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (c == 5) chk("inflight_busy", int'(busy), 1);
      if (c == 8) begin
        set_ops(1, 0, 3, 0);
        start = 1'b1;
      end
      if (c == 9) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("inflight_lat", lat, 22);
    chk("inflight_rr", int'(resultreal), 7);
    chk("inflight_ri", int'(resultimaginary), 1);
    repeat (2) @(posedge clk);

    // Held start: successive done pulses ND+3 cycles apart.
    @(negedge clk);
    set_ops(1, 0, 3, 0);
    start = 1'b1;
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (done && k < 3) begin
        t[k] = c;
        k++;
      end
      if (k == 3) break;
    end
    start = 1'b0;
    chk("b2b_pulses", k, 3);
    if (k == 3) begin
      chk("b2b_first", t[0], 22);
      chk("b2b_gap1", t[1] - t[0], 23);
      chk("b2b_gap2", t[2] - t[1], 23);
    end
    chk("b2b_rr", int'(resultreal), 5);
    repeat (2) @(posedge clk);

    // Asynchronous reset during the 10th DIV cycle.
    @(negedge clk);
    set_ops(10, 20, 30, 40);
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    chk("mid_busy_before", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_dbz", int'(div_by_zero), 0);
    chk("mid_rst_rr", int'(resultreal), 0);
    chk("mid_rst_ri", int'(resultimaginary), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    run_op(3, 4, 1, 0, lat);
    chk("post_rst_lat", lat, 22);
    chk("post_rst_rr", int'(resultreal), 48);
    chk("post_rst_ri", int'(resultimaginary), 64);
    chk("post_rst_dbz", int'(div_by_zero), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
